udiv16by8_seq: RTL and testbench



---
 rtl/udiv16by8_seq_pkg.sv | 18 +
 rtl/udiv16by8_seq_if.sv | 29 ++
 rtl/udiv16by8_seq_step.sv | 28 ++
 rtl/udiv16by8_seq.sv | 120 ++++++++++++
 tb/tb_udiv16by8_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/udiv16by8_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the iteration-counter width helper.
package udiv16by8_seq_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index N iterations; keep at least one bit for degenerate N.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udiv16by8_seq_if.sv
// Start/done request bus between a requester (master) and the divider (slave).
// Operands are sampled on the accept edge; results and flags are held until the next accept.
interface udiv16by8_seq_if
  import udiv16by8_seq_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           dbz;
  logic           ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovf
  );

endinterface

// File: rtl/udiv16by8_seq_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational.
module udiv_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] r,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_next,
  output logic         qbit
);

  logic [N:0] trial;
  logic [N:0] diff;

  assign trial = {r, bit_in};
  assign diff  = trial - {1'b0, divisor};

  always_comb begin
    r_next = trial[N-1:0];
    qbit   = 1'b0;
    if (trial >= {1'b0, divisor}) begin
      r_next = diff[N-1:0];
      qbit   = 1'b1;
    end
  end

endmodule

// File: rtl/udiv16by8_seq.sv
// Sequential 2N/N unsigned restoring divider, one quotient bit per clock (N cycles busy).
// Start is accepted in IDLE or DONE and ignored while RUN; error cases finish in one cycle.
module udiv16by8_seq
  import udiv16by8_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input logic            clk,
  input logic            rst,
  udiv16by8_seq_if.slave bus
);

  localparam int CW = cnt_width(N);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  r_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  rem_q;
  logic          dbz_q;
  logic          ovf_q;
  logic [CW-1:0] cnt;

  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [N-1:0]  r_nxt;
  logic [N-1:0]  q_nxt;
  logic          qbit;
  logic          accept;
  logic          div_zero;
  logic          hi_ovf;
  logic          last;

  assign hi       = bus.dividend[2*N-1:N];
  assign lo       = bus.dividend[N-1:0];
  assign accept   = bus.start && (state != RUN);
  assign div_zero = (bus.divisor == '0);
  assign hi_ovf   = !div_zero && (hi >= bus.divisor);
  assign last     = (cnt == CW'(N - 1));
  assign q_nxt    = {q_q[N-2:0], qbit};

  udiv_step #(.N(N)) u_step (
    .r       (r_q),
    .bit_in  (q_q[N-1]),
    .divisor (dvs_q),
    .r_next  (r_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          state_nxt = (div_zero || hi_ovf) ? DONE : RUN;
        end
      end
      RUN:     state_nxt = last ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      if (div_zero || hi_ovf) begin
        // Saturated result marks an unusable quotient; flags say why.
        quo_q <= '1;
        rem_q <= '1;
        dbz_q <= div_zero;
        ovf_q <= hi_ovf;
      end else begin
        dvs_q <= bus.divisor;
        r_q   <= hi;
        q_q   <= lo;
        cnt   <= '0;
        dbz_q <= 1'b0;
        ovf_q <= 1'b0;
      end
    end else if (state == RUN) begin
      r_q <= r_nxt;
      q_q <= q_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        quo_q <= q_nxt;
        rem_q <= r_nxt;
      end
    end
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_udiv16by8_seq.sv
// Bench for udiv16by8_seq: transaction-level divide model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_udiv16by8_seq;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udiv16by8_seq_if #(.N(N)) bus ();

  udiv16by8_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 iterating (m_left edges to go), 2 done pulse.
  bit         m_valid = 1'b0;
  int         m_phase = 0;
  int         m_left  = 0;
  int         md, mv, p_q, p_r;
  logic [7:0] m_q = '0;
  logic [7:0] m_r = '0;
  logic       m_dbz = 1'b0;
  logic       m_ovf = 1'b0;

  always @(posedge clk) begin
    md = int'(bus.dividend);
    mv = int'(bus.divisor);
    if (rst) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_left  = 0;
      m_q = '0; m_r = '0; m_dbz = 1'b0; m_ovf = 1'b0;
    end else if (bus.start && m_phase != 1) begin
      if (mv == 0) begin
        m_phase = 2; m_q = 8'hFF; m_r = 8'hFF; m_dbz = 1'b1; m_ovf = 1'b0;
      end else if (md / 256 >= mv) begin
        m_phase = 2; m_q = 8'hFF; m_r = 8'hFF; m_dbz = 1'b0; m_ovf = 1'b1;
      end else begin
        m_phase = 1; m_left = N;
        p_q = md / mv; p_r = md % mv;
        m_dbz = 1'b0; m_ovf = 1'b0;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_phase = 2; m_q = 8'(p_q); m_r = 8'(p_r);
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_busy", 32'(bus.busy), 32'(m_phase == 1));
      chk("cyc_done", 32'(bus.done), 32'(m_phase == 2));
      chk("cyc_quotient", 32'(bus.quotient), 32'(m_q));
      chk("cyc_remainder", 32'(bus.remainder), 32'(m_r));
      chk("cyc_dbz", 32'(bus.dbz), 32'(m_dbz));
      chk("cyc_ovf", 32'(bus.ovf), 32'(m_ovf));
    end
  end

  // Called at posedge+1 with the divider not iterating; returns at accept-edge+1.
  task automatic launch(input logic [15:0] dd, input logic [7:0] dv);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  // lat = clock edges after the accept edge until done is seen (bounded).
  task automatic wait_done(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string name, input logic [15:0] dd, input logic [7:0] dv,
                       input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                       input logic eovf, input int elat, input int ebusy);
    int lat, bcnt;
    launch(dd, dv);
    wait_done(0, lat, bcnt);
    chk({name, "_latency"}, 32'(lat), 32'(elat));
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'(ebusy));
    chk({name, "_quotient"}, 32'(bus.quotient), 32'(eq));
    chk({name, "_remainder"}, 32'(bus.remainder), 32'(er));
    chk({name, "_dbz"}, 32'(bus.dbz), 32'(edbz));
    chk({name, "_ovf"}, 32'(bus.ovf), 32'(eovf));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, bcnt;
    logic [7:0]  rdv;
    logic [15:0] rdd;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_quotient", 32'(bus.quotient), 32'd0);
    chk("reset_remainder", 32'(bus.remainder), 32'd0);
    chk("reset_flags", 32'({bus.dbz, bus.ovf}), 32'd0);

    do_op("d30000_150", 16'd30000, 8'd150, 8'd200, 8'd0, 1'b0, 1'b0, 8, 8);
    do_op("d65025_255", 16'd65025, 8'd255, 8'd255, 8'd0, 1'b0, 1'b0, 8, 8);
    do_op("d30001_150", 16'd30001, 8'd150, 8'd200, 8'd1, 1'b0, 1'b0, 8, 8);
    do_op("dbz", 16'h1234, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0);
    do_op("ovf", 16'h1234, 8'h12, 8'hFF, 8'hFF, 1'b0, 1'b1, 0, 0);
    do_op("d1000_10", 16'd1000, 8'd10, 8'd100, 8'd0, 1'b0, 1'b0, 8, 8);

    // Second start three edges into the iteration must be ignored.
    launch(16'd30000, 8'd150);
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(4, lat, bcnt);
    chk("ignore_latency", 32'(lat), 32'd8);
    chk("ignore_quotient", 32'(bus.quotient), 32'd200);
    chk("ignore_remainder", 32'(bus.remainder), 32'd0);
    @(posedge clk); #1;

    // Reset four edges into an iteration aborts it with cleared outputs.
    launch(16'd30000, 8'd150);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    rst = 1'b0;
    do_op("d100_7", 16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8, 8);

    // Start held high: the second pair is accepted in the DONE cycle.
    bus.dividend = 16'd30000; bus.divisor = 8'd150; bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done(0, lat, bcnt);
    chk("held1_latency", 32'(lat), 32'd8);
    chk("held1_quotient", 32'(bus.quotient), 32'd200);
    chk("held1_remainder", 32'(bus.remainder), 32'd0);
    bus.dividend = 16'd1000; bus.divisor = 8'd10;
    @(posedge clk); #1;
    chk("held2_done_low", 32'(bus.done), 32'd0);
    chk("held2_busy", 32'(bus.busy), 32'd1);
    wait_done(0, lat, bcnt);
    chk("held2_latency", 32'(lat), 32'd8);
    chk("held2_quotient", 32'(bus.quotient), 32'd100);
    chk("held2_remainder", 32'(bus.remainder), 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("held_idle", 32'({bus.busy, bus.done}), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      rdv = 8'($urandom_range(1, 255));
      rdd = 16'($urandom % (int'(rdv) * 256));
      launch(rdd, rdv);
      wait_done(0, lat, bcnt);
      chk("rnd_latency", 32'(lat), 32'd8);
      chk("rnd_invariant", 32'(bus.quotient) * 32'(rdv) + 32'(bus.remainder), 32'(rdd));
      chk("rnd_rem_lt_div", 32'(bus.remainder < rdv), 32'd1);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
